// File: rtl/glyph_blitter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : glyph_blitter_pkg
// Description : Shared display constants for the notepad glyph path: glyph
//               geometry, screen-cell field widths, the blitter state
//               encoding and the glyph bitmap bit-index rule. The ASCII glyph
//               lookup uses the same geometry constants.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package glyph_blitter_pkg;

  // Glyph geometry: 8 px wide, 16 rows, row 0 in the top byte, MSB leftmost.
  localparam int GLYPH_W    = 8;
  localparam int GLYPH_H    = 16;
  localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
  localparam int PIX_W      = $clog2(GLYPH_BITS);
  localparam int COLB_W     = $clog2(GLYPH_W);
  localparam int ROWB_W     = $clog2(GLYPH_H);

  // Character-cell and colour field widths on the framebuffer side.
  localparam int COL_W   = 5;
  localparam int ROW_W   = 3;
  localparam int COLOR_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit of the 128-bit bitmap that holds pixel (r, c).
  function automatic logic [PIX_W-1:0] glyph_bit_idx(
    input logic [ROWB_W-1:0] r,
    input logic [COLB_W-1:0] c
  );
    return PIX_W'(GLYPH_BITS - 1 - GLYPH_W * int'(r) - int'(c));
  endfunction

endpackage : glyph_blitter_pkg
`default_nettype wire

// File: rtl/glyph_blitter_if.sv
`default_nettype none
// ============================================================================
// Module      : glyph_blitter_if
// Description : Request and plot bus of the glyph blitter.
//   Request side : start, char_x, char_y, glyph, fg, bg, transparent -> blitter
//                  busy, done                                        <- blitter
//   Plot side    : x, y, colour, plot                                <- blitter
//                  stall                                             -> blitter
//   slave  : the blitter's view;  master : the requester/adapter view.
// Revision    : 1.0 - initial release
// ============================================================================
interface glyph_blitter_if;
  import glyph_blitter_pkg::*;

  logic                  start;
  logic [COL_W-1:0]      char_x;
  logic [ROW_W-1:0]      char_y;
  logic [GLYPH_BITS-1:0] glyph;
  logic [COLOR_W-1:0]    fg;
  logic [COLOR_W-1:0]    bg;
  logic                  transparent;
  logic                  stall;
  logic                  busy;
  logic                  done;
  logic [COL_W+2:0]      x;
  logic [ROW_W+3:0]      y;
  logic [COLOR_W-1:0]    colour;
  logic                  plot;

  modport slave (
    input  start, char_x, char_y, glyph, fg, bg, transparent, stall,
    output busy, done, x, y, colour, plot
  );

  modport master (
    output start, char_x, char_y, glyph, fg, bg, transparent, stall,
    input  busy, done, x, y, colour, plot
  );

endinterface : glyph_blitter_if
`default_nettype wire

// File: rtl/glyph_blitter_pixel_counter.sv
`default_nettype none
// ============================================================================
// Module      : glyph_pixel_counter
// Description : Pixel index counter for one glyph (row-major, 0..127).
//   clock_i  : clock
//   resetn_i : asynchronous active-low reset
//   clr_i    : synchronous clear (request accepted); wins over en_i
//   en_i     : advance by one pixel
//   pix_o    : current pixel index
//   last_o   : current pixel is the final one of the glyph
// Revision    : 1.0 - initial release
// ============================================================================
module glyph_pixel_counter
  import glyph_blitter_pkg::*;
(
  input  logic             clock_i,
  input  logic             resetn_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [PIX_W-1:0] pix_o,
  output logic             last_o
);

  logic [PIX_W-1:0] pix_q;

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      pix_q <= '0;
    end else if (clr_i) begin
      pix_q <= '0;
    end else if (en_i) begin
      pix_q <= pix_q + PIX_W'(1);
    end
  end

  assign pix_o  = pix_q;
  assign last_o = (pix_q == PIX_W'(GLYPH_BITS - 1));

endmodule : glyph_pixel_counter
`default_nettype wire

// File: rtl/glyph_blitter.sv
`default_nettype none
// ============================================================================
// Module      : glyph_blitter
// Description : Writes one 8x16 glyph bitmap into the framebuffer at a
//               character cell, one pixel per cycle, through the VGA
//               adapter's plot interface.
//   clock_i  : clock, all state on rising edge
//   resetn_i : asynchronous active-low reset
//   bus      : glyph_blitter_if.slave (request inputs, busy/done, plot bus
//              with stall back-pressure)
//   COLS/ROWS: on-screen character grid; cells outside it finish with no plots
// Revision    : 1.0 - initial release
// ============================================================================
module glyph_blitter
  import glyph_blitter_pkg::*;
#(
  parameter int COLS = 20,
  parameter int ROWS = 7
)
(
  input  logic           clock_i,
  input  logic           resetn_i,
  glyph_blitter_if.slave bus
);

  localparam logic [COL_W-1:0] COLS_LIM = COL_W'(COLS);
  localparam logic [ROW_W-1:0] ROWS_LIM = ROW_W'(ROWS);

  state_e                state_q;
  logic [COL_W-1:0]      cx_q;
  logic [ROW_W-1:0]      cy_q;
  logic [GLYPH_BITS-1:0] glyph_q;
  logic [COLOR_W-1:0]    fg_q;
  logic [COLOR_W-1:0]    bg_q;
  logic                  transp_q;
  logic                  busy_q;
  logic                  done_q;
  logic [COL_W+2:0]      x_q;
  logic [ROW_W+3:0]      y_q;
  logic [COLOR_W-1:0]    colour_q;
  logic                  plot_q;

  logic                  accept;
  logic                  in_range;
  logic                  cnt_en;
  logic [PIX_W-1:0]      pix;
  logic                  pix_last;
  logic [PIX_W-1:0]      pix_nxt_d;
  logic [ROWB_W-1:0]     row_nxt_d;
  logic [COLB_W-1:0]     col_nxt_d;
  logic                  bit_nxt_d;
  logic                  bit_first;

  assign accept   = (state_q == ST_IDLE) && bus.start;
  assign in_range = (bus.char_x < COLS_LIM) && (bus.char_y < ROWS_LIM);
  assign cnt_en   = (state_q == ST_DRAW) && !bus.stall;

  glyph_pixel_counter u_pix_cnt (
    .clock_i  (clock_i),
    .resetn_i (resetn_i),
    .clr_i    (accept),
    .en_i     (cnt_en),
    .pix_o    (pix),
    .last_o   (pix_last)
  );

  // Outputs are registered, so each consumed pixel loads the following
  // pixel's coordinates and colour; pixel 0 is loaded straight from the
  // request inputs on the accepting edge.
  assign pix_nxt_d = pix + PIX_W'(1);
  assign row_nxt_d = pix_nxt_d[PIX_W-1:COLB_W];
  assign col_nxt_d = pix_nxt_d[COLB_W-1:0];
  assign bit_nxt_d = glyph_q[glyph_bit_idx(row_nxt_d, col_nxt_d)];
  assign bit_first = bus.glyph[glyph_bit_idx('0, '0)];

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= ST_IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      glyph_q  <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      transp_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          plot_q <= 1'b0;
          if (bus.start) begin
            cx_q     <= bus.char_x;
            cy_q     <= bus.char_y;
            glyph_q  <= bus.glyph;
            fg_q     <= bus.fg;
            bg_q     <= bus.bg;
            transp_q <= bus.transparent;
            busy_q   <= 1'b1;
            if (in_range) begin
              state_q  <= ST_DRAW;
              x_q      <= {bus.char_x, COLB_W'(0)};
              y_q      <= {bus.char_y, ROWB_W'(0)};
              colour_q <= bit_first ? bus.fg : bus.bg;
              plot_q   <= bit_first | ~bus.transparent;
            end else begin
              // Off-screen cell: report completion without touching pixels.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        ST_DRAW: begin
          if (!bus.stall) begin
            if (pix_last) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              plot_q  <= 1'b0;
            end else begin
              x_q      <= {cx_q, col_nxt_d};
              y_q      <= {cy_q, row_nxt_d};
              colour_q <= bit_nxt_d ? fg_q : bg_q;
              plot_q   <= bit_nxt_d | ~transp_q;
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          plot_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          plot_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.x      = x_q;
  assign bus.y      = y_q;
  assign bus.colour = colour_q;
  assign bus.plot   = plot_q;

endmodule : glyph_blitter
`default_nettype wire

// File: tb/tb_glyph_blitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_glyph_blitter
// Description : Scoreboard bench for glyph_blitter. The driver computes the
//               expected plot list and done cycle for each request from the
//               glyph rules and queues them; a negedge monitor pops and
//               compares whenever the blitter plots or signals done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glyph_blitter;
  import glyph_blitter_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct packed {
    logic [COL_W+2:0]   x;
    logic [ROW_W+3:0]   y;
    logic [COLOR_W-1:0] c;
  } pix_t;

  pix_t exp_q[$];
  int   done_q[$];

  glyph_blitter_if bus();

  glyph_blitter #(.COLS(20), .ROWS(7)) dut (
    .clock_i  (clk),
    .resetn_i (resetn),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic scramble();
    bus.glyph  = {$urandom, $urandom, $urandom, $urandom};
    bus.char_x = COL_W'($urandom);
    bus.char_y = ROW_W'($urandom);
    bus.fg     = COLOR_W'($urandom);
    bus.bg     = COLOR_W'($urandom);
    bus.transparent = 1'($urandom);
  endtask

  // Monitor: a pixel is delivered when plot is high and stall is low; while
  // stalled the held pixel must still equal the head of the queue.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.plot) begin
        chk("plot_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          chk(bus.stall ? "held_pixel" : "pixel",
              32'({bus.x, bus.y, bus.colour}), 32'(exp_q[0]));
          if (!bus.stall) void'(exp_q.pop_front());
        end
      end
      if (bus.done) begin
        chk("done_expected", 32'(done_q.size() > 0), 1);
        if (done_q.size() > 0) begin
          chk("done_cycle", cyc, done_q.pop_front());
          chk("plots_left_at_done", exp_q.size(), 0);
        end
      end
    end
  end

  // One request. stall_pct: random stall probability per cycle; hold_at:
  // pixel index at which 10 consecutive stall cycles are inserted (-1 none);
  // abort_at: pixel index at which reset is pulsed (-1 none); pulse: raise
  // start for one cycle mid-draw with junk request fields.
  task automatic do_req(input logic [127:0] g, input int cx, input int cy,
                        input int fg, input int bg, input bit tr,
                        input int stall_pct, input int hold_at,
                        input int abort_at, input bit pulse);
    int   a;
    int   consumed;
    int   nst;
    int   held;
    bit   pulsed;
    bit   s;
    pix_t p;
    @(posedge clk); #1;
    bus.glyph       = g;
    bus.char_x      = COL_W'(cx);
    bus.char_y      = ROW_W'(cy);
    bus.fg          = COLOR_W'(fg);
    bus.bg          = COLOR_W'(bg);
    bus.transparent = tr;
    bus.stall       = 1'($urandom);
    bus.start       = 1'b1;
    @(posedge clk); #1;
    a = cyc;
    bus.start = 1'b0;
    scramble();
    chk("busy_after_accept", bus.busy, 1);
    if (!(cx < 20 && cy < 7)) begin
      done_q.push_back(a);
      return;
    end
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (g[127 - 8*r - c] || !tr) begin
          p.x = (COL_W+3)'(cx*8 + c);
          p.y = (ROW_W+4)'(cy*16 + r);
          p.c = g[127 - 8*r - c] ? COLOR_W'(fg) : COLOR_W'(bg);
          exp_q.push_back(p);
        end
      end
    end
    consumed = 0; nst = 0; held = 0; pulsed = 0;
    while (consumed < 128) begin
      if (consumed == abort_at) begin
        resetn = 1'b0;
        #1;
        chk("reset_mid_draw",
            32'({bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour}), 0);
        exp_q.delete();
        done_q.delete();
        bus.stall = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        return;
      end
      s = 1'b0;
      if (consumed == hold_at && held < 10) begin
        s = 1'b1;
        held++;
      end else if ($urandom_range(0, 99) < stall_pct) begin
        s = 1'b1;
      end
      if (pulse && consumed == 80 && !pulsed) begin
        scramble();
        bus.start = 1'b1;
        pulsed = 1;
      end else begin
        bus.start = 1'b0;
      end
      bus.stall = s;
      if (s) nst++;
      else   consumed++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.stall = 1'($urandom);
    done_q.push_back(a + 128 + nst);
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: actual timeout required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    scramble();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      scramble();
      bus.start = 1'($urandom);
      bus.stall = 1'($urandom);
      @(negedge clk);
      chk("reset_outputs",
          32'({bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.colour}), 0);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    resetn    = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'({bus.busy, bus.done, bus.plot}), 0);

    // Single set pixel at the top-left of cell (0,0), opaque.
    do_req(128'h1 << 127, 0, 0, 7, 0, 1'b0, 0, -1, -1, 1'b0);
    // All-ones glyph in the bottom-right cell.
    do_req({128{1'b1}}, 19, 6, 5, 2, 1'b0, 0, -1, -1, 1'b0);
    // Transparent: only row 5 = 00111100 in cell (1,0).
    do_req(128'h3C << 80, 1, 0, 6, 1, 1'b1, 0, -1, -1, 1'b0);
    // 10-cycle stall at pixel 40 plus a start pulse mid-draw.
    do_req({$urandom, $urandom, $urandom, $urandom}, 3, 2, 4, 3, 1'b0, 0, 40, -1, 1'b1);
    // Off-screen cells.
    do_req({128{1'b1}}, 20, 0, 7, 7, 1'b0, 0, -1, -1, 1'b0);
    do_req({128{1'b1}}, 0, 7, 7, 7, 1'b0, 0, -1, -1, 1'b0);
    // Reset at pixel 64, then a fresh request.
    do_req({$urandom, $urandom, $urandom, $urandom}, 5, 3, 2, 5, 1'b0, 0, -1, 64, 1'b0);
    do_req({$urandom, $urandom, $urandom, $urandom}, 5, 3, 2, 5, 1'b0, 0, -1, -1, 1'b0);
    // Randomized requests with random back-pressure.
    for (int n = 0; n < 10; n++) begin
      do_req({$urandom, $urandom, $urandom, $urandom},
             int'($urandom_range(0, 21)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             1'($urandom), 25, -1, -1, 1'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("pixels_outstanding", exp_q.size(), 0);
    chk("dones_outstanding", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_glyph_blitter
`default_nettype wire

// File: doc/glyph_blitter.md
# glyph_blitter

Sequential consumer of 128-bit character glyph bitmaps: takes one glyph (8 px wide × 16 rows, row 0 in bits [127:120], MSB = leftmost pixel) plus a character-cell position and writes it into the pixel framebuffer, one pixel per cycle, through the VGA adapter's plot interface (x, y, colour, plot). It sits between the ASCII-to-glyph lookup and the VGA adapter in the notepad display path, turning the decoded bitmap back into screen pixels.

## Interface
- COLS, 20, character columns on screen (160 px / 8)
- ROWS, 7, character rows on screen (112 of 120 px / 16)
- COL_W, 5, width of char_x
- ROW_W, 3, width of char_y
- COLOR_W, 3, colour width
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- char_x  in  COL_W  character column of request
- char_y  in  ROW_W  character row of request
- glyph  in  128  bitmap; pixel (r,c) = glyph[127 − 8r − c]
- fg  in  COLOR_W  colour for set bits
- bg  in  COLOR_W  colour for clear bits
- transparent  in  1  1: clear bits are not plotted
- stall  in  1  downstream not ready; current pixel is held
- busy  out  1  high from the cycle after acceptance through DONE
- done  out  1  one-cycle pulse at end of request
- x  out  COL_W+3  pixel x
- y  out  ROW_W+4  pixel y
- colour  out  COLOR_W  pixel colour
- plot  out  1  write strobe for current pixel

## Operation
- States: IDLE, DRAW, DONE.
- IDLE: busy=0. On start=1, latch glyph, char_x, char_y, fg, bg, transparent. Next state is DRAW with pix=0, or DONE if char_x ≥ COLS or char_y ≥ ROWS (no plots).
- DRAW: 7-bit counter pix; r = pix[6:3], c = pix[2:0]. Outputs: x = char_x·8 + c, y = char_y·16 + r, colour = bit ? fg : bg, plot = bit | ~transparent. A pixel is consumed on each edge with stall=0: pix increments, or the state goes to DONE if pix = 127. With stall=1, pix and all outputs hold. Transparent background pixels still occupy one cycle.
- DONE: done=1 and busy=1 for one cycle, plot=0, then IDLE.
- start is ignored in DRAW and DONE. Changes on the glyph/position inputs after acceptance have no effect.
- Arithmetic: the x/y concatenations are unsigned and exact (char_x<<3 | c, char_y<<4 | r); no overflow is possible for in-range cells.
- stall has no effect outside DRAW.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, pix=0, busy=0, done=0, plot=0, x=0, y=0, colour=0, latched regs=0.
- start accepted at edge k: pixel 0 is on the outputs during cycle k+1.
- With no stall, pixel n is on the outputs in cycle k+1+n. done is high in cycle k+129. IDLE starts in cycle k+130, so the earliest next accept is at edge k+130.
- Each stall cycle adds one cycle of latency.
- Out-of-range request: done is high in cycle k+1 and no plot is issued.
- Reset mid-DRAW: outputs return to reset values immediately and the partial glyph is abandoned.

## Structure
- Shared display package: GLYPH_W=8, GLYPH_H=16, GLYPH_BITS=128, the state encoding, and the bit-index rule 127 − 8r − c. The ASCII glyph lookup uses the same constants.
- One sub-module: glyph_pixel_counter (7-bit counter with enable = DRAW & ~stall, clear on accept, terminal flag at 127).
- Top level wires the lookup's 128-bit output directly to glyph.

## Test plan
- Reset with all inputs toggling -> all outputs 0, busy 0. A start pulse while resetn=0 is ignored.
- glyph=1<<127, cell (0,0), fg=7, bg=0, opaque -> pixel 0 at (0,0) colour 7; 127 further plots colour 0; last at (7,15); done in cycle k+129.
- glyph all ones, cell (19,6) -> first plot (152,96), last (159,111), all colour fg, 128 plots.
- transparent=1, glyph with only row 5 = 8'b00111100, cell (1,0) -> exactly 4 plots at (10..13, 5); done still in cycle k+129.
- stall=1 for 10 cycles while pix=40, plus start pulsed mid-draw -> x/y/colour held; 128 distinct pixels with no duplicate or skip; done in cycle k+139; extra start ignored.
- char_x=20 -> zero plots, done in cycle k+1. Separately, resetn pulsed low at pix=64 -> plot=0 at once; a fresh start redraws from pixel 0.
